tx_pace_scheduler: RTL and testbench

- Parametrised successor to the switch-driven rate/segment/redundancy decoder.
- Decodes the DIP-switch config, runs the packet-rate interval counter, and sequences each interval's burst of segments and redundant copies into the TX frame builder over a valid/ready handshake.
- Adds:
  - shadowed config, so switch changes never corrupt a burst in flight;
  - a programmable inter-packet gap;
  - frame sequence numbering;
  - sticky overrun detection.
- Sits between the switch inputs and the Ethernet TX packet generator.

---
 rtl/tx_pace_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_tx_pace_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pace_scheduler.sv
// tx_pace_scheduler: decodes the DIP-switch rate/segment/redundancy config,
// runs the packet-rate interval counter and sequences each interval's burst
// of segment copies into the TX frame builder.
//
// Handshake: tx_valid/tx_ready follow strict valid/ready semantics. A request
// is transferred on every rising clk edge where tx_valid && tx_ready. While
// tx_valid is high and tx_ready is low, tx_valid and all tx_* fields are held
// unchanged. tx_valid never drops without a transfer, except on reset.
// tx_ready is ignored whenever tx_valid is low.
module tx_pace_scheduler #(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned SEG_W      = 16,
  parameter int unsigned RED_W      = 8,
  parameter int unsigned SEQ_W      = 16,
  parameter int unsigned IPG_CYC    = 12,
  parameter int unsigned MIN_PERIOD = 30,
  parameter int unsigned SEG_TBL0   = 1,
  parameter int unsigned SEG_TBL1   = 5,
  parameter int unsigned SEG_TBL2   = 50,
  parameter int unsigned SEG_TBL3   = 100,
  parameter int unsigned RED_TBL0   = 1,
  parameter int unsigned RED_TBL1   = 3,
  parameter int unsigned RED_TBL2   = 5,
  parameter int unsigned RED_TBL3   = 7
) (
  input  logic             clk125MHz,
  input  logic             rst_n,
  input  logic [7:0]       switches,
  input  logic             enable,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [SEG_W-1:0] tx_seg_idx,
  output logic [SEG_W-1:0] tx_seg_max,
  output logic [RED_W-1:0] tx_copy_idx,
  output logic [RED_W-1:0] tx_redundancy,
  output logic [SEQ_W-1:0] tx_seq,
  output logic             busy,
  output logic             overrun,
  output logic [15:0]      missed_ticks,
  input  logic             clr_overrun
);

  // Gap counter holds IPG_CYC-1 down to 0.
  localparam int unsigned GAP_W    = (IPG_CYC > 2) ? $clog2(IPG_CYC) : 1;
  localparam int unsigned GAP_LOAD = (IPG_CYC > 0) ? IPG_CYC - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   term;
  logic               tick;
  logic [SEG_W-1:0]   seg_max_q;
  logic [RED_W-1:0]   red_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic               gap_to_idle;
  logic               last_copy;
  logic               last_pkt;

  // Terminal count of the interval counter for each rate code.
  function automatic logic [CNT_W-1:0] period_of(input logic [3:0] code);
    case (code)
      4'h0:    period_of = CNT_W'(CLK_HZ / 1 - 1);
      4'h1:    period_of = CNT_W'(CLK_HZ / 2 - 1);
      4'h2:    period_of = CNT_W'(CLK_HZ / 10 - 1);
      4'h3:    period_of = CNT_W'(CLK_HZ / 20 - 1);
      4'h4:    period_of = CNT_W'(CLK_HZ / 50 - 1);
      4'h5:    period_of = CNT_W'(CLK_HZ / 100 - 1);
      4'h6:    period_of = CNT_W'(CLK_HZ / 200 - 1);
      4'h7:    period_of = CNT_W'(CLK_HZ / 500 - 1);
      4'h8:    period_of = CNT_W'(CLK_HZ / 1000 - 1);
      4'h9:    period_of = CNT_W'(CLK_HZ / 2000 - 1);
      4'hA:    period_of = CNT_W'(CLK_HZ / 5000 - 1);
      4'hB:    period_of = CNT_W'(CLK_HZ / 10000 - 1);
      4'hC:    period_of = CNT_W'(CLK_HZ / 20000 - 1);
      4'hD:    period_of = CNT_W'(CLK_HZ / 50000 - 1);
      4'hE:    period_of = CNT_W'(CLK_HZ / 100000 - 1);
      default: period_of = CNT_W'(MIN_PERIOD);
    endcase
  endfunction

  function automatic logic [SEG_W-1:0] seg_of(input logic [1:0] sel);
    case (sel)
      2'd0:    seg_of = SEG_W'(SEG_TBL0);
      2'd1:    seg_of = SEG_W'(SEG_TBL1);
      2'd2:    seg_of = SEG_W'(SEG_TBL2);
      default: seg_of = SEG_W'(SEG_TBL3);
    endcase
  endfunction

  function automatic logic [RED_W-1:0] red_of(input logic [1:0] sel);
    case (sel)
      2'd0:    red_of = RED_W'(RED_TBL0);
      2'd1:    red_of = RED_W'(RED_TBL1);
      2'd2:    red_of = RED_W'(RED_TBL2);
      default: red_of = RED_W'(RED_TBL3);
    endcase
  endfunction

  assign tick      = (cnt == term);
  assign last_copy = (tx_copy_idx == red_q - 1'b1);
  assign last_pkt  = last_copy && (tx_seg_idx == seg_max_q - 1'b1);

  // Free-running interval counter; the period is only re-read at a wrap.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      cnt  <= '0;
      term <= period_of(switches[3:0]);
    end else if (tick) begin
      cnt  <= '0;
      term <= period_of(switches[3:0]);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Burst sequencer: walks copies within segments, with optional gaps.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      tx_seg_idx    <= '0;
      tx_copy_idx   <= '0;
      tx_seg_max    <= '0;
      tx_redundancy <= '0;
      tx_seq        <= '0;
      seg_max_q     <= seg_of(switches[7:6]);
      red_q         <= red_of(switches[5:4]);
      gap_cnt       <= '0;
      gap_to_idle   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && enable) begin
            seg_max_q     <= seg_of(switches[7:6]);
            red_q         <= red_of(switches[5:4]);
            tx_seg_max    <= seg_of(switches[7:6]);
            tx_redundancy <= red_of(switches[5:4]);
            tx_seg_idx    <= '0;
            tx_copy_idx   <= '0;
            state         <= ISSUE;
            tx_valid      <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ISSUE: begin
          if (tx_ready) begin
            if (last_copy) begin
              tx_copy_idx <= '0;
              tx_seg_idx  <= tx_seg_idx + 1'b1;
            end else begin
              tx_copy_idx <= tx_copy_idx + 1'b1;
            end
            if (last_pkt) begin
              tx_seq <= tx_seq + 1'b1;
            end
            gap_to_idle <= last_pkt;
            if (IPG_CYC > 0) begin
              state    <= GAP;
              gap_cnt  <= GAP_W'(GAP_LOAD);
              tx_valid <= 1'b0;
            end else if (last_pkt) begin
              state    <= IDLE;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            if (gap_to_idle) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= ISSUE;
              tx_valid <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a tick landing while a burst is still running is dropped.
  always_ff @(posedge clk125MHz) begin
    if (!rst_n) begin
      overrun      <= 1'b0;
      missed_ticks <= '0;
    end else if (tick && (state != IDLE)) begin
      overrun <= 1'b1;
      if (clr_overrun) begin
        missed_ticks <= 16'd1;
      end else if (missed_ticks != 16'hFFFF) begin
        missed_ticks <= missed_ticks + 16'd1;
      end
    end else if (clr_overrun) begin
      overrun      <= 1'b0;
      missed_ticks <= '0;
    end
  end

endmodule

// File: tb/tb_tx_pace_scheduler.sv
// Bench for tx_pace_scheduler: two instances (back-to-back and 12-cycle gap)
// share stimulus; a packet-index model predicts every output each cycle.
module tb_tx_pace_scheduler;

  localparam int CLK_HZ = 125000000;
  localparam int MIN_P  = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst_n       = 1'b0;
  logic [7:0] switches    = 8'h1F;
  logic       enable      = 1'b1;
  logic       tx_ready    = 1'b1;
  logic       clr_overrun = 1'b0;

  logic        o_valid   [2];
  logic [15:0] o_seg_idx [2];
  logic [15:0] o_seg_max [2];
  logic [7:0]  o_copy    [2];
  logic [7:0]  o_red     [2];
  logic [15:0] o_seq     [2];
  logic        o_busy    [2];
  logic        o_ovr     [2];
  logic [15:0] o_miss    [2];

  tx_pace_scheduler #(.IPG_CYC(0)) d0 (
    .clk125MHz(clk), .rst_n(rst_n), .switches(switches), .enable(enable),
    .tx_valid(o_valid[0]), .tx_ready(tx_ready), .tx_seg_idx(o_seg_idx[0]),
    .tx_seg_max(o_seg_max[0]), .tx_copy_idx(o_copy[0]), .tx_redundancy(o_red[0]),
    .tx_seq(o_seq[0]), .busy(o_busy[0]), .overrun(o_ovr[0]),
    .missed_ticks(o_miss[0]), .clr_overrun(clr_overrun)
  );

  tx_pace_scheduler #(.IPG_CYC(12)) d1 (
    .clk125MHz(clk), .rst_n(rst_n), .switches(switches), .enable(enable),
    .tx_valid(o_valid[1]), .tx_ready(tx_ready), .tx_seg_idx(o_seg_idx[1]),
    .tx_seg_max(o_seg_max[1]), .tx_copy_idx(o_copy[1]), .tx_redundancy(o_red[1]),
    .tx_seq(o_seq[1]), .busy(o_busy[1]), .overrun(o_ovr[1]),
    .missed_ticks(o_miss[1]), .clr_overrun(clr_overrun)
  );

  int ipg [2] = '{0, 12};

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, idx, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pps_tbl [15] = '{1, 2, 10, 20, 50, 100, 200, 500, 1000, 2000, 5000,
                       10000, 20000, 50000, 100000};

  function automatic int interval_cycles(input logic [3:0] code);
    if (code == 4'hF) return MIN_P + 1;
    return CLK_HZ / pps_tbl[code];
  endfunction

  function automatic int seg_of(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 5;
      2'd2: return 50;
      default: return 100;
    endcase
  endfunction

  function automatic int red_of(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 3;
      2'd2: return 5;
      default: return 7;
    endcase
  endfunction

  bit m_live = 1'b0;
  int m_phase;          // cycles elapsed in the current interval
  int m_len;            // length of the current interval in cycles
  bit m_act   [2];      // burst running, including any trailing gap
  int m_k     [2];      // packets accepted so far in this burst
  int m_total [2];
  int m_gap   [2];      // idle cycles still owed
  int m_seg   [2];
  int m_red   [2];
  int m_oseg  [2];
  int m_ored  [2];
  int m_seq   [2];
  bit m_ovr   [2];
  int m_miss  [2];

  function automatic bit exp_valid(input int i);
    return m_act[i] && (m_gap[i] == 0) && (m_k[i] < m_total[i]);
  endfunction

  always @(posedge clk) begin
    bit tick;
    bit was_act;
    if (!rst_n) begin
      m_live  = 1'b1;
      m_phase = 0;
      m_len   = interval_cycles(switches[3:0]);
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_k[i] = 0; m_total[i] = 0; m_gap[i] = 0;
        m_seg[i] = seg_of(switches[7:6]); m_red[i] = red_of(switches[5:4]);
        m_oseg[i] = 0; m_ored[i] = 0; m_seq[i] = 0; m_ovr[i] = 1'b0; m_miss[i] = 0;
      end
    end else begin
      tick = (m_phase == m_len - 1);
      if (tick) begin
        m_phase = 0;
        m_len   = interval_cycles(switches[3:0]);
      end else begin
        m_phase++;
      end
      for (int i = 0; i < 2; i++) begin
        was_act = m_act[i];
        if (was_act) begin
          if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0 && m_k[i] == m_total[i]) m_act[i] = 1'b0;
          end else if (tx_ready) begin
            m_k[i]++;
            if (m_k[i] == m_total[i]) begin
              m_seq[i] = (m_seq[i] + 1) % 65536;
              if (ipg[i] == 0) m_act[i] = 1'b0;
            end
            if (ipg[i] > 0) m_gap[i] = ipg[i];
          end
        end
        if (tick && was_act) begin
          m_ovr[i]  = 1'b1;
          m_miss[i] = clr_overrun ? 1 : ((m_miss[i] < 65535) ? m_miss[i] + 1 : 65535);
        end else if (clr_overrun) begin
          m_ovr[i]  = 1'b0;
          m_miss[i] = 0;
        end
        if (tick && !was_act && enable) begin
          m_act[i]   = 1'b1;
          m_k[i]     = 0;
          m_gap[i]   = 0;
          m_seg[i]   = seg_of(switches[7:6]);
          m_red[i]   = red_of(switches[5:4]);
          m_oseg[i]  = m_seg[i];
          m_ored[i]  = m_red[i];
          m_total[i] = m_seg[i] * m_red[i];
        end
      end
    end
  end

  // ---------------- per-cycle compare + accept bookkeeping ----------------
  int  acc [2] = '{0, 0};
  int  cyc = 0;
  bit  prev_v0 = 1'b0;
  int  rises[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 2; i++) begin
        check("tx_valid",      i, o_valid[i],   exp_valid(i));
        check("tx_seg_idx",    i, o_seg_idx[i], m_k[i] / m_red[i]);
        check("tx_copy_idx",   i, o_copy[i],    m_k[i] % m_red[i]);
        check("tx_seg_max",    i, o_seg_max[i], m_oseg[i]);
        check("tx_redundancy", i, o_red[i],     m_ored[i]);
        check("tx_seq",        i, o_seq[i],     m_seq[i]);
        check("busy",          i, o_busy[i],    m_act[i]);
        check("overrun",       i, o_ovr[i],     m_ovr[i]);
        check("missed_ticks",  i, o_miss[i],    m_miss[i]);
        if (o_valid[i] && tx_ready) acc[i]++;
      end
      if (o_valid[0] && !prev_v0) rises.push_back(cyc);
      prev_v0 = o_valid[0];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [7:0] sw);
    switches = sw;
    rst_n    = 1'b0;
    cycles(1);
    rst_n    = 1'b1;
    acc[0]   = 0;
    acc[1]   = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fcyc;
    int r0;
    int r1;

    // 1/2: code F, red 3, seg 1; interval 31 cycles
    enable   = 1'b1;
    tx_ready = 1'b1;
    do_reset(8'h1F);
    check("reset_valid",   0, o_valid[0],   0);
    check("reset_seq",     0, o_seq[0],     0);
    check("reset_seg_max", 0, o_seg_max[0], 0);
    cycles(100);
    check("t1_accepts",  0, acc[0],    9);
    check("t1_seq",      0, o_seq[0],  3);
    check("t1_overrun",  0, o_ovr[0],  0);
    check("t2_accepts",  1, acc[1],    4);
    check("t2_overrun",  1, o_ovr[1],  1);
    check("t2_missed",   1, o_miss[1], 1);
    enable = 1'b0;
    cycles(40);
    check("idle_tick_ignored", 0, acc[0],   9);
    check("idle_no_overrun",   0, o_ovr[0], 0);
    enable = 1'b1;

    // 3: seg 5, red 5, code 8 loaded at the first wrap; random ready
    do_reset(8'h6F);
    switches = 8'h68;
    for (int c = 0; c < 800; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (c == 35) enable = 1'b0;
      cycles(1);
    end
    tx_ready = 1'b1;
    enable   = 1'b1;
    check("t3_accepts",  0, acc[0],       25);
    check("t3_accepts",  1, acc[1],       25);
    check("t3_seq",      0, o_seq[0],     1);
    check("t3_seq",      1, o_seq[1],     1);
    check("t3_seg_end",  0, o_seg_idx[0], 5);
    check("t3_idle",     1, o_busy[1],    0);

    // 4: seg 5 -> seg 100 mid-burst, red 1, code F
    do_reset(8'h4F);
    cycles(33);
    switches = 8'hCF;
    cycles(137);
    check("t4_accepts", 0, acc[0],       105);
    check("t4_seq",     0, o_seq[0],     2);
    check("t4_missed",  0, o_miss[0],    3);
    check("t4_seg_max", 0, o_seg_max[0], 100);
    cycles(4);
    clr_overrun = 1'b1;
    cycles(1);
    clr_overrun = 1'b0;
    check("clr_overrun", 0, o_ovr[0],  0);
    check("clr_missed",  0, o_miss[0], 0);
    cycles(41);
    clr_overrun = 1'b1;
    cycles(1);
    clr_overrun = 1'b0;
    check("set_wins_overrun", 0, o_ovr[0],  1);
    check("set_wins_missed",  0, o_miss[0], 1);

    // 5: 1 pps interval, code F selected mid-interval, counter forced near its end
    do_reset(8'h00);
    cycles(5);
    switches = 8'h0F;
    cycles(5);
    rises.delete();
    fcyc = cyc;
    force d0.cnt = 28'(CLK_HZ - 3);
    force d1.cnt = 28'(CLK_HZ - 3);
    m_phase = m_len - 3;
    #1;
    release d0.cnt;
    release d1.cnt;
    cycles(40);
    r0 = (rises.size() > 0) ? rises[0] : -1;
    r1 = (rises.size() > 1) ? rises[1] : -1;
    check("t5_bursts",       0, rises.size(), 2);
    check("t5_old_period",   0, r0 - fcyc,    3);
    check("t5_new_period",   0, r1 - r0,      31);

    // 6: reset while a burst is stalled in ISSUE
    do_reset(8'h2F);
    cycles(55);
    tx_ready = 1'b0;
    cycles(39);
    check("t6_pre_seq",     0, o_seq[0],  1);
    check("t6_pre_overrun", 0, o_ovr[0],  1);
    check("t6_pre_valid",   0, o_valid[0], 1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("t6_valid",   0, o_valid[0], 0);
    check("t6_busy",    0, o_busy[0],  0);
    check("t6_seq",     0, o_seq[0],   0);
    check("t6_overrun", 0, o_ovr[0],   0);
    check("t6_overrun", 1, o_ovr[1],   0);
    tx_ready = 1'b1;
    cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
